// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
// sram_controller_if : memory-stage load/store handshake to the SRAM controller
// Revision: 1.0
// ============================================================================
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// sram_controller : 32-bit load/store over a 16-bit async SRAM, two half-words
// Revision: 1.0
// ============================================================================
module sram_controller #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sram_controller_if.slave bus,
  inout  wire logic [15:0] SRAM_DQ,
  output logic      [17:0] SRAM_ADDR,
  output logic             SRAM_WE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] c_wait_last = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] w_diff;
  logic        w_req;
  logic        w_drive;
  logic [15:0] w_dq_out;
  logic        w_unused;

  assign w_req  = bus.wr_en | bus.rd_en;
  // Wrapping subtraction; only bits [18:2] select the 32-bit word.
  assign w_diff   = bus.address - BASE_ADDR;
  assign w_unused = ^{w_diff[31:19], w_diff[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    SRAM_ADDR = 18'd0;
    w_drive   = 1'b0;
    w_dq_out  = r_wdata[15:0];
    case (r_state)
      S_IDLE: if (w_req) w_next = S_LO;
      S_LO: begin
        w_next    = S_HI;
        SRAM_ADDR = {r_word, 1'b0};
        w_drive   = r_is_wr;
        w_dq_out  = r_wdata[15:0];
      end
      S_HI: begin
        w_next    = S_WAIT;
        SRAM_ADDR = {r_word, 1'b1};
        w_drive   = r_is_wr;
        w_dq_out  = r_wdata[31:16];
      end
      S_WAIT: if (r_cnt == c_wait_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    SRAM_WE_N = ~w_drive;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_word  <= 17'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_is_wr <= bus.wr_en;
        r_word  <= w_diff[18:2];
        r_wdata <= bus.write_data;
      end
      if (r_state == S_WAIT) begin
        r_cnt <= (r_cnt == c_wait_last) ? 4'd0 : r_cnt + 4'd1;
      end
      if (!r_is_wr && r_state == S_LO) r_rdata[15:0]  <= SRAM_DQ;
      if (!r_is_wr && r_state == S_HI) r_rdata[31:16] <= SRAM_DQ;
    end
  end

  assign SRAM_DQ       = w_drive ? w_dq_out : 16'hzzzz;
  assign bus.ready     = ~(w_req && (r_state != S_DONE));
  assign bus.read_data = r_rdata;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign SRAM_CE_N     = 1'b0;
  assign SRAM_OE_N     = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// tb_sram_controller : table vectors, corner sequences and random traffic
// Revision: 1.0
// ============================================================================
module tb_sram_controller;
  localparam int          c_wait = 3;
  localparam logic [31:0] c_base = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  sram_controller_if bus();

  sram_controller #(.WAIT_CYCLES(c_wait), .BASE_ADDR(c_base)) dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // External SRAM: drives the bus whenever it is not being written.
  logic [15:0] sram [0:262143];
  assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_last_rd = 32'd0;
  logic [15:0] ref_mem [int unsigned];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [17:0] a_lo;
    logic [31:0] rdata;
  } vec_t;
  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] hw_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - c_base;
    return 18'(((off % 32'h80000) / 4) * 2);
  endfunction

  // Called right after inputs are driven at a negedge; returns at DONE.
  task automatic observe(input bit scramble, output int lowcnt, output int wecnt,
                         output logic [17:0] a1, output logic [17:0] a2, output bit ok);
    bit done;
    done = 0; lowcnt = 0; wecnt = 0; a1 = '0; a2 = '0;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (bus.ready) done = 1; else lowcnt++;
      if (!SRAM_WE_N) wecnt++;
      if (k == 1) a1 = SRAM_ADDR;
      if (k == 2) a2 = SRAM_ADDR;
      if (!done) begin
        @(negedge clk);
        if (scramble) begin
          bus.address    = $urandom;
          bus.write_data = $urandom;
        end
      end
    end
    ok = done;
  endtask

  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input bit scramble, input string tag,
                        input logic [17:0] exp_a, input logic [31:0] exp_rd);
    int lowcnt, wecnt;
    logic [17:0] a1, a2;
    bit ok;
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = wd;
    observe(scramble, lowcnt, wecnt, a1, a2, ok);
    chk({tag, " done_in_budget"}, 32'(ok), 32'd1);
    chk({tag, " ready_low_cycles"}, lowcnt, 3 + c_wait);
    chk({tag, " we_low_cycles"}, wecnt, wr ? 2 : 0);
    chk({tag, " addr_lo"}, 32'(a1), 32'(exp_a));
    chk({tag, " addr_hi"}, 32'(a2), 32'(exp_a + 18'd1));
    chk({tag, " read_data"}, bus.read_data, exp_rd);
    if (wr) begin
      chk({tag, " sram_lo"}, 32'(sram[exp_a]), 32'(wd[15:0]));
      chk({tag, " sram_hi"}, 32'(sram[exp_a + 18'd1]), 32'(wd[31:16]));
    end else begin
      m_last_rd = exp_rd;
    end
    bus.wr_en = 0; bus.rd_en = 0;
  endtask

  initial begin
    int lowcnt, wecnt;
    logic [17:0] a1, a2, hw;
    bit ok;
    logic [31:0] pool [8];
    logic [31:0] wd, exp;
    int unsigned p, op;
    bit scr;

    vec[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h00000, 32'h00000000};
    vec[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 32'hDEADBEEF};
    vec[2] = '{1'b1, 1'b0, 32'd1031, 32'hCAFEF00D, 18'h00002, 32'hDEADBEEF};
    vec[3] = '{1'b0, 1'b1, 32'd1031, 32'h00000000, 18'h00002, 32'hCAFEF00D};
    vec[4] = '{1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 18'h3FFFE, 32'hCAFEF00D};
    vec[5] = '{1'b0, 1'b1, 32'd1020, 32'h00000000, 18'h3FFFE, 32'h0BADC0DE};
    vec[6] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'h00000, 32'h0BADC0DE};
    vec[7] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 32'h12345678};

    rst = 1'b1;
    bus.wr_en = 0; bus.rd_en = 0; bus.address = 0; bus.write_data = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready_idle", 32'(bus.ready), 32'd1);
    chk("reset we_n", 32'(SRAM_WE_N), 32'd1);
    chk("reset sram_addr", 32'(SRAM_ADDR), 32'd0);
    chk("reset read_data", bus.read_data, 32'd0);
    chk("tied strobes", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'd0);
    bus.rd_en = 1;
    #1;
    chk("reset ready_with_req", 32'(bus.ready), 32'd0);
    bus.rd_en = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_txn(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wd, 1'b0,
             $sformatf("vec%0d", i), vec[i].a_lo, vec[i].rdata);
    end

    // Back-to-back reads with rd_en held high throughout.
    @(negedge clk);
    bus.rd_en = 1; bus.address = 32'd1024;
    observe(1'b0, lowcnt, wecnt, a1, a2, ok);
    chk("b2b first ready_low", lowcnt, 3 + c_wait);
    chk("b2b first read_data", bus.read_data, 32'h12345678);
    @(negedge clk);
    observe(1'b0, lowcnt, wecnt, a1, a2, ok);
    chk("b2b second ready_low", lowcnt, 3 + c_wait);
    chk("b2b second addr_lo", 32'(a1), 32'd0);
    chk("b2b second read_data", bus.read_data, 32'h12345678);
    bus.rd_en = 0;

    // Reset during HI of a write: upper half must never reach the SRAM.
    @(negedge clk);
    bus.wr_en = 1; bus.address = 32'd1024; bus.write_data = 32'h99998888;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort hi we_n", 32'(SRAM_WE_N), 32'd0);
    chk("abort hi addr", 32'(SRAM_ADDR), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort sram_addr", 32'(SRAM_ADDR), 32'd0);
    chk("abort read_data", bus.read_data, 32'd0);
    chk("abort ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    chk("abort sram_lo", 32'(sram[0]), 32'h8888);
    chk("abort sram_hi", 32'(sram[1]), 32'h1234);
    m_last_rd = 32'd0;
    rst = 1'b0;
    observe(1'b0, lowcnt, wecnt, a1, a2, ok);
    chk("restart ready_low", lowcnt, 3 + c_wait);
    chk("restart we_low", wecnt, 2);
    chk("restart sram_hi", 32'(sram[1]), 32'h9999);
    chk("restart read_data", bus.read_data, 32'd0);
    bus.wr_en = 0;

    // Random traffic over a small address pool, wrapping addresses included.
    for (int i = 0; i < 8; i++) begin
      pool[i] = (i < 4) ? $urandom : c_base + $urandom_range(0, 4095);
    end
    for (int i = 0; i < 48; i++) begin
      p   = (i < 8) ? i : $urandom_range(0, 7);
      op  = (i < 8) ? 0 : $urandom_range(0, 2);
      scr = 1'($urandom_range(0, 1));
      wd  = $urandom;
      hw  = hw_of(pool[p]);
      if (op == 1) begin
        exp = {ref_mem[32'(hw) + 1], ref_mem[32'(hw)]};
        do_txn(1'b0, 1'b1, pool[p], wd, scr, $sformatf("rand%0d_rd", i), hw, exp);
      end else begin
        do_txn(1'b1, op == 2, pool[p], wd, scr, $sformatf("rand%0d_wr", i), hw, m_last_rd);
        ref_mem[32'(hw)]     = wd[15:0];
        ref_mem[32'(hw) + 1] = wd[31:16];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
